// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock under a
// start/done handshake. Each trial subtraction is a + ~b + 1, matching the
// add/subtract datapath in subtract mode.
module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div0
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned REM_W = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] rem_nx;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH-1:0] qreg_nx;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] divisor_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  logic             busy_nx;
  logic             done_nx;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] r_nx;
  logic             div0_nx;

  logic [REM_W-1:0] shifted;
  logic [REM_W-1:0] trial;
  logic [REM_W-1:0] rem_step;
  logic [WIDTH-1:0] qreg_step;
  logic             last_iter;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
  assign shifted   = REM_W'({rem, qreg[WIDTH-1]});
  assign trial     = shifted + ~{1'b0, divisor} + REM_W'(1);
  assign rem_step  = trial[REM_W-1] ? shifted : trial;
  assign qreg_step = {qreg[WIDTH-2:0], ~trial[REM_W-1]};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a zero divisor short-circuits straight to DONE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (b == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (last_iter) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Next values for the datapath and the registered outputs.
  always_comb begin
    rem_nx     = rem;
    qreg_nx    = qreg;
    divisor_nx = divisor;
    cnt_nx     = cnt;
    q_nx       = q;
    r_nx       = r;
    div0_nx    = div0;
    busy_nx    = (state_nx != S_IDLE);
    done_nx    = (state_nx == S_DONE);
    case (state)
      S_IDLE: begin
        if (start) begin
          qreg_nx    = a;
          divisor_nx = b;
          rem_nx     = '0;
          cnt_nx     = '0;
          if (b == '0) begin
            q_nx    = '1;
            r_nx    = a;
            div0_nx = 1'b1;
          end
        end
      end
      S_CALC: begin
        rem_nx  = rem_step;
        qreg_nx = qreg_step;
        cnt_nx  = cnt + CNT_W'(1);
        if (last_iter) begin
          q_nx    = qreg_step;
          r_nx    = rem_step[WIDTH-1:0];
          div0_nx = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      qreg    <= '0;
      divisor <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      q       <= '0;
      r       <= '0;
      div0    <= 1'b0;
    end else begin
      rem     <= rem_nx;
      qreg    <= qreg_nx;
      divisor <= divisor_nx;
      cnt     <= cnt_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      q       <= q_nx;
      r       <= r_nx;
      div0    <= div0_nx;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

  localparam int unsigned W    = 4;
  localparam int unsigned MASK = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div0;

  int unsigned n_vec;
  int unsigned n_bad;

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .div0  (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one request from a point just after a rising edge with the DUT idle,
  // optionally spraying start with junk operands while it computes.
  task automatic run_op(input int unsigned av, input int unsigned bv, input bit noise);
    int unsigned eq, er, ed, elat;
    int cyc;
    bit seen;
    if (bv == 0) begin
      eq = MASK; er = av; ed = 1; elat = 0;
    end else begin
      eq = av / bv; er = av % bv; ed = 0; elat = W;
    end
    start = 1'b1;
    a = W'(av);
    b = W'(bv);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_e0", 32'(busy), 1);
    cyc  = 0;
    seen = done;
    while (!seen && cyc < 20) begin
      if (noise) begin
        start = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      seen = done;
      if (!seen) check("busy_calc", 32'(busy), 1);
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
    end else begin
      check("latency", 32'(cyc), elat);
      check("q", 32'(q), eq);
      check("r", 32'(r), er);
      check("div0", 32'(div0), ed);
      check("busy_done", 32'(busy), 1);
      if (bv != 0) begin
        check("inv_qbr", 32'(q) * bv + 32'(r), av);
        check("inv_rltb", 32'(32'(r) < bv), 1);
      end
    end
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 0);
    check("busy_after", 32'(busy), 0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_q", 32'(q), 0);
    check("rst_r", 32'(r), 0);
    check("rst_div0", 32'(div0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic and corner cases.
    run_op(13, 4, 1'b0);
    run_op(15, 1, 1'b0);
    run_op(3, 7, 1'b0);
    run_op(0, 5, 1'b0);
    run_op(15, 15, 1'b0);
    run_op(9, 0, 1'b0);
    run_op(8, 2, 1'b0);

    // Start during CALC must be ignored, and not queued.
    run_op(13, 4, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
      check("no_requeue_done", 32'(done), 0);
      check("no_requeue_busy", 32'(busy), 0);
    end

    // Reset in the middle of an operation.
    start = 1'b1;
    a = W'(14);
    b = W'(3);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_q", 32'(q), 0);
    check("midrst_r", 32'(r), 0);
    check("midrst_div0", 32'(div0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_done", 32'(done), 0);
    run_op(14, 3, 1'b0);

    // Every operand pair, back to back at full rate.
    for (int ia = 0; ia <= int'(MASK); ia++) begin
      for (int ib = 0; ib <= int'(MASK); ib++) begin
        run_op(ia, ib, 1'b0);
      end
    end

    // Random operands with random start noise.
    for (int k = 0; k < 40; k++) begin
      run_op($urandom_range(MASK, 0), $urandom_range(MASK, 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
